// File: rtl/display_driver.sv
// Four-digit multiplexed seven-segment driver for the core's r7 / PC outputs.
// One snapshot per scan frame keeps all digits coherent; outputs lag the scan by one cycle.
module display_driver #(
  parameter int PC_WIDTH    = 6,
  parameter int REFRESH_DIV = 100000,
  parameter bit BLANK_ZEROS = 1'b1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [15:0]         r7_data,
  input  logic [PC_WIDTH-1:0] pc_in,
  input  logic                show_pc,
  output logic [3:0]          anode,
  output logic [6:0]          seg,
  output logic                dp,
  output logic                update_pulse
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_P     = 7'b0001100;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   snap_q, snap_d;
  logic          mode_q, mode_d;
  logic [3:0]    anode_q, anode_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic          pulse_q, pulse_d;

  logic          tick, wrap, lz_blank;
  logic [7:0]    pc8;
  logic [3:0]    nib;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;
      4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  always_comb begin
    tick  = (cnt_q == CW'(REFRESH_DIV - 1));
    wrap  = tick && (idx_q == 2'd3);
    cnt_d = tick ? '0 : cnt_q + 1'b1;
    idx_d = tick ? idx_q + 1'b1 : idx_q;

    pc8 = '0;
    pc8[PC_WIDTH-1:0] = pc_in;

    snap_d  = snap_q;
    mode_d  = mode_q;
    pulse_d = 1'b0;
    if (wrap) begin
      snap_d  = show_pc ? {8'h00, pc8} : r7_data;
      mode_d  = show_pc;
      pulse_d = (snap_d != snap_q) || (mode_d != mode_q);
    end

    // Display path decodes the current (pre-update) index and snapshot.
    nib = snap_q[{idx_q, 2'b00} +: 4];
    case (idx_q)
      2'd1:    lz_blank = (snap_q[15:4]  == '0);
      2'd2:    lz_blank = (snap_q[15:8]  == '0);
      2'd3:    lz_blank = (snap_q[15:12] == '0);
      default: lz_blank = 1'b0;
    endcase

    if (mode_q) begin
      if (idx_q == 2'd3)      seg_d = SEG_P;
      else if (idx_q == 2'd2) seg_d = SEG_BLANK;
      else                    seg_d = hex7(nib);
    end else if (BLANK_ZEROS && lz_blank) begin
      seg_d = SEG_BLANK;
    end else begin
      seg_d = hex7(nib);
    end

    anode_d = ~(4'b0001 << idx_q);
    dp_d    = ~(mode_q && (idx_q == 2'd0));
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      snap_q  <= '0;
      mode_q  <= 1'b0;
      anode_q <= '1;
      seg_q   <= '1;
      dp_q    <= 1'b1;
      pulse_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
      mode_q  <= mode_d;
      anode_q <= anode_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      pulse_q <= pulse_d;
    end
  end

  assign anode        = anode_q;
  assign seg          = seg_q;
  assign dp           = dp_q;
  assign update_pulse = pulse_q;

endmodule

// File: tb/tb_display_driver.sv
// Directed bench for display_driver with REFRESH_DIV=4; two instances differ only in BLANK_ZEROS.
module tb_display_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] r7;
  logic [5:0]  pc;
  logic        show_pc;

  logic [3:0] an_a, an_b;
  logic [6:0] seg_a, seg_b;
  logic       dp_a, dp_b, up_a, up_b;

  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned e     = 0;

  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                         S3 = 7'b0110000, S4 = 7'b0011001, SA = 7'b0001000,
                         SB = 7'b0000011, SF = 7'b0001110, SP = 7'b0001100,
                         SX = 7'b1111111;

  always #5 clk = ~clk;

  display_driver #(.PC_WIDTH(6), .REFRESH_DIV(4), .BLANK_ZEROS(1'b1)) dut_a (
    .clock(clk), .reset(rst), .r7_data(r7), .pc_in(pc), .show_pc(show_pc),
    .anode(an_a), .seg(seg_a), .dp(dp_a), .update_pulse(up_a)
  );

  display_driver #(.PC_WIDTH(6), .REFRESH_DIV(4), .BLANK_ZEROS(1'b0)) dut_b (
    .clock(clk), .reset(rst), .r7_data(r7), .pc_in(pc), .show_pc(show_pc),
    .anode(an_b), .seg(seg_b), .dp(dp_b), .update_pulse(up_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h (edge %0d)", tag, got, exp, e);
    end
  endtask

  // Advance to a given edge count after reset release, then settle 1 ns past the edge.
  task automatic adv(input int unsigned n);
    while (e < n) begin
      @(posedge clk);
      e++;
    end
    #1;
  endtask

  task automatic chk_a(input string tag, input logic [3:0] an, input logic [6:0] sg,
                       input logic d, input logic up);
    chk(tag, {an_a, seg_a, dp_a, up_a}, {an, sg, d, up});
  endtask

  task automatic chk_b(input string tag, input logic [3:0] an, input logic [6:0] sg,
                       input logic d, input logic up);
    chk(tag, {an_b, seg_b, dp_b, up_b}, {an, sg, d, up});
  endtask

  initial begin
    rst = 1'b0; r7 = 16'h1234; pc = '0; show_pc = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_a("reset_a", 4'b1111, SX, 1'b1, 1'b0);
    chk_b("reset_b", 4'b1111, SX, 1'b1, 1'b0);
    rst = 1'b1;
    e = 0;

    // Frame 1: snapshot 0x0000
    adv(1);  chk_a("f1_d0_a", 4'b1110, S0, 1'b1, 1'b0);
    adv(5);  chk_a("f1_d1_blank", 4'b1101, SX, 1'b1, 1'b0);
             chk_b("f1_d1_noblank", 4'b1101, S0, 1'b1, 1'b0);
    adv(13); chk_a("f1_d3_blank", 4'b0111, SX, 1'b1, 1'b0);
    adv(16); chk("wrap1_pulse", {31'd0, up_a}, 32'd1);
    adv(17); chk("wrap1_pulse_1cyc", {31'd0, up_a}, 32'd0);

    // Frame 2: 0x1234
    chk_a("f2_d0", 4'b1110, S4, 1'b1, 1'b0);
    adv(20); chk_a("f2_d0_hold", 4'b1110, S4, 1'b1, 1'b0);
    adv(21); chk_a("f2_d1", 4'b1101, S3, 1'b1, 1'b0);
    adv(25); chk_a("f2_d2", 4'b1011, S2, 1'b1, 1'b0);
    adv(29); chk_a("f2_d3", 4'b0111, S1, 1'b1, 1'b0);
    adv(32); chk("wrap2_nochange", {31'd0, up_a}, 32'd0);

    // Frame 3: input changes while digit 1 is lit
    adv(37); chk_a("f3_d1", 4'b1101, S3, 1'b1, 1'b0);
    r7 = 16'hFFFF;
    adv(41); chk_a("f3_d2_stale", 4'b1011, S2, 1'b1, 1'b0);
    adv(45); chk_a("f3_d3_stale", 4'b0111, S1, 1'b1, 1'b0);
    adv(48); chk("wrap3_pulse", {31'd0, up_a}, 32'd1);

    // Frame 4: 0xFFFF
    adv(49); chk_a("f4_d0", 4'b1110, SF, 1'b1, 1'b0);
    r7 = 16'h00A0;
    adv(53); chk_a("f4_d1", 4'b1101, SF, 1'b1, 1'b0);
    adv(64); chk("wrap4_pulse", {31'd0, up_b}, 32'd1);

    // Frame 5: 0x00A0, blanking vs no blanking
    adv(65); chk_a("f5_d0_a", 4'b1110, S0, 1'b1, 1'b0);
    adv(69); chk_a("f5_d1_a", 4'b1101, SA, 1'b1, 1'b0);
             chk_b("f5_d1_b", 4'b1101, SA, 1'b1, 1'b0);
    adv(73); chk_a("f5_d2_a", 4'b1011, SX, 1'b1, 1'b0);
             chk_b("f5_d2_b", 4'b1011, S0, 1'b1, 1'b0);
    adv(77); chk_a("f5_d3_a", 4'b0111, SX, 1'b1, 1'b0);
             chk_b("f5_d3_b", 4'b0111, S0, 1'b1, 1'b0);
    show_pc = 1'b1; pc = 6'h2B;
    adv(80); chk("wrap5_pulse", {31'd0, up_a}, 32'd1);

    // Frame 6: PC view of 0x2B
    adv(81); chk_a("pc_d0", 4'b1110, SB, 1'b0, 1'b0);
    adv(85); chk_a("pc_d1", 4'b1101, S2, 1'b1, 1'b0);
    adv(89); chk_a("pc_d2", 4'b1011, SX, 1'b1, 1'b0);
             chk_b("pc_d2_b", 4'b1011, SX, 1'b1, 1'b0);
    adv(93); chk_a("pc_d3", 4'b0111, SP, 1'b1, 1'b0);
    adv(96); chk("wrap6_nochange", {31'd0, up_a}, 32'd0);

    // Reset while index=2, counter=2 (before edge 107)
    adv(106);
    rst = 1'b0;
    adv(107); chk_a("midscan_reset", 4'b1111, SX, 1'b1, 1'b0);
    rst = 1'b1;
    e = 0;
    adv(1);  chk_a("restart_d0", 4'b1110, S0, 1'b1, 1'b0);
    adv(4);  chk_a("restart_cnt0", 4'b1110, S0, 1'b1, 1'b0);
    adv(5);  chk_a("restart_d1", 4'b1101, SX, 1'b1, 1'b0);
    adv(16); chk("restart_wrap_pulse", {31'd0, up_a}, 32'd1);
    adv(17); chk_a("restart_pc_d0", 4'b1110, SB, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/display_driver.md
Name: display_driver

Overview:
- Output stage directly downstream of the CPU core on the FPGA board. Consumes the core's r7 result bus and program counter and drives a 4-digit, common-anode, time-multiplexed seven-segment display.
- Snapshots the value once per scan frame so all four digits always come from the same sample.
- Supports leading-zero blanking and a PC-view mode.
- Flags each frame whose displayed value differs from the previous frame's.

Parameters:
- PC_WIDTH, 6, width of pc_in; must be ≤ 8.
- REFRESH_DIV, 100000, clock cycles each digit stays lit; must be ≥ 1.
- BLANK_ZEROS, 1, 1 = blank leading zero digits; 0 = show all digits.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-low reset.
- r7_data  input  16  value from the core's register r7.
- pc_in  input  PC_WIDTH  core program counter.
- show_pc  input  1  1 = display PC instead of r7.
- anode  output  4  digit enables, active-low; bit i = digit i; digit 0 is rightmost.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  output  1  decimal point, active-low.
- update_pulse  output  1  one-cycle high when a newly loaded snapshot differs from the previous one.

Behaviour:
- Reset: applied when reset == 0 on a rising clock edge. All registers load in the same cycle:
  - refresh counter = 0, digit index = 0, snapshot value = 0x0000, snapshot mode = 0;
  - anode = 4'b1111, seg = 7'b1111111, dp = 1, update_pulse = 0.
- Reset mid-scan: identical to power-on reset; the scan restarts at digit 0.
- Refresh counter: counts 0 .. REFRESH_DIV-1 and then wraps. tick = (counter == REFRESH_DIV-1). With REFRESH_DIV = 1, tick is high every cycle.
- Digit index: 2-bit register; increments on tick; wraps 3 → 0.
- Frame wrap: tick && index == 3. On frame wrap, in the same edge:
  - snapshot value ← r7_data, or ← {zero-extended pc_in to 8 bits} when show_pc = 1;
  - snapshot mode ← show_pc;
  - update_pulse ← (new value != old value) || (new mode != old mode).
  - update_pulse is 0 on every other cycle.
- Inputs are ignored between frame wraps. Changes mid-frame have no visible effect until the next wrap.
- Output latency: anode, seg and dp are registered and reflect the index and snapshot from the previous cycle (1-cycle latency). After reset is released, the first edge drives digit 0 of snapshot 0x0000.
- anode: index 0 → 1110, 1 → 1101, 2 → 1011, 3 → 0111. Exactly one bit is low except during reset.
- Digit content, r7 mode (mode = 0): digit i shows snapshot nibble [4i+3:4i].
- Digit content, PC mode (mode = 1):
  - digit 3 = letter P (0001100);
  - digit 2 = blank;
  - digits 1 and 0 = high and low nibbles of the 8-bit PC.
  - Blanking does not apply in PC mode.
- Leading-zero blanking (BLANK_ZEROS = 1, mode 0): digit i (i ≥ 1) is blank when nibble i and all higher nibbles are zero. Digit 0 is never blanked, so 0x0000 shows a single "0".
- Hex encoding {g..a}, active-low:
  - 0: 1000000, 1: 1111001, 2: 0100100, 3: 0110000
  - 4: 0011001, 5: 0010010, 6: 0000010, 7: 1111000
  - 8: 0000000, 9: 0010000, A: 0001000, b: 0000011
  - C: 1000110, d: 0100001, E: 0000110, F: 0001110
  - blank: 1111111
- dp: 0 (lit) only when digit 0 is active and the snapshot mode is PC mode. Otherwise 1.
- Simultaneous reset and tick: reset wins.
- Simultaneous frame wrap and show_pc change: the new mode is captured, and the whole next frame uses it.

Test Plan:
1. REFRESH_DIV = 4; hold reset = 0 for 3 cycles with r7_data = 0x1234 → anode = 1111, seg = 1111111, dp = 1, update_pulse = 0. After release, the first frame shows anode = 1110, seg = 1000000 (digit 0 = "0"); digits 1–3 are blank.
2. r7_data = 0x1234 held → at the first frame wrap (cycle 16 after release) update_pulse = 1 for one cycle. The next frame shows:
   - anode 1110 with seg 0011001 ("4"), then 1101 with 0110000 ("3"), then 1011 with 0100100 ("2"), then 0111 with 1111001 ("1");
   - each digit lasts 4 cycles.
   - The following wrap with an unchanged input gives update_pulse = 0.
3. r7_data = 0x00A0, BLANK_ZEROS = 1 → digits 3 and 2 show 1111111, digit 1 shows 0001000 ("A"), digit 0 shows 1000000 ("0"). With BLANK_ZEROS = 0, all four digits are shown.
4. r7_data changes 0x1234 → 0xFFFF while digit 1 is active → the rest of the frame still shows 1,2,3,4. 0xFFFF appears only after the next wrap, and update_pulse fires at that wrap.
5. show_pc = 1, pc_in = 6'h2B → after the wrap:
   - digit 3 shows 0001100 ("P"), digit 2 is blank;
   - digit 1 shows 0100100 ("2"), digit 0 shows 0000011 ("b") with dp = 0;
   - update_pulse = 1.
6. Assert reset = 0 for one cycle while index = 2 and counter = 2 → the next edge gives reset outputs. After release, the scan restarts at digit 0 with the counter at 0 and the snapshot at 0x0000.
